// File: rtl/parity_scan_ctrl_pkg.sv
// Shared types and constants for the parity scan controller.
// Holds the FSM state encoding, the parity-sense constants and the default field width.
package parity_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/parity_unit.sv
// Combinational parity check of one 32-bit word plus its transmitted parity bit.
// Flags the word when the 33-bit parity does not match the requested sense.
module parity_unit
   import parity_scan_ctrl_pkg::*;
(
   input  logic [31:0] data,
   input  logic        par,
   input  logic        mode,
   output logic        fail
);

   logic odd_ones;

   assign odd_ones = (^data) ^ par;
   assign fail     = (odd_ones ? PAR_ODD : PAR_EVEN) != mode;

endmodule

// File: rtl/parity_scan_ctrl.sv
// Burst parity scanner: accepts len words after start, counts parity failures
// and records the index of the first failing word; results hold until the next start.
module parity_scan_ctrl
   import parity_scan_ctrl_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             in_par,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] err_cnt,
   output logic             err_flag,
   output logic [LEN_W-1:0] first_err_idx
);

   localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_next;
   logic             mode_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx;
   logic             accept;
   logic             word_fail;
   logic             last_word;
   logic             start_ok;

   parity_unit u_parity (
      .data (in_data),
      .par  (in_par),
      .mode (mode_q),
      .fail (word_fail)
   );

   assign in_ready  = (state == RUN);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign last_word = (idx == len_q - ONE);
   assign start_ok  = (state == IDLE) & start;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (accept && last_word) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Burst context is captured only on an accepted start, so pin changes mid-burst are invisible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q        <= PAR_EVEN;
         len_q         <= '0;
         idx           <= '0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         first_err_idx <= '0;
      end else if (start_ok) begin
         mode_q        <= mode;
         len_q         <= len;
         idx           <= '0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         first_err_idx <= '0;
      end else if (accept) begin
         idx <= idx + ONE;
         if (word_fail) begin
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + ONE;
            end
            if (!err_flag) begin
               err_flag      <= 1'b1;
               first_err_idx <= idx;
            end
         end
      end
   end

endmodule
